// File: rtl/zombie_pkg.sv
// ---------------------------------------------------------------------------
// zombie_pkg
// Shared definitions for the whack-a-zombie round controller:
//   - FSM state encoding (IDLE, GAP, UP, DONE)
//   - LFSR seed and feedback tap mask
//   - hole-index to one-hot LED mapping
// ---------------------------------------------------------------------------
package zombie_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_GAP  = 2'd1;
  localparam state_t ST_UP   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1, shifting left: feedback = q[7]^q[5]^q[4]^q[3]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Two random bits pick one of three holes; code 3 folds onto hole 2.
  function automatic logic [2:0] hole_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    case (sel)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      2'd3:    oh = 3'b010;
      default: oh = 3'b010;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/zombie_lfsr.sv
// ---------------------------------------------------------------------------
// zombie_lfsr
// Free-running 8-bit Fibonacci LFSR, reloaded with LFSR_SEED on reset and
// advanced on every clock.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   q_o  out current LFSR state [7:0]
// ---------------------------------------------------------------------------
module zombie_lfsr
  import zombie_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // next LFSR value: shift left, feedback is parity of the tapped bits
  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // LFSR state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/zombie_round_ctrl.sv
// ---------------------------------------------------------------------------
// zombie_round_ctrl
// Game sequencer for the three-hole whack-a-zombie board. Lights a
// pseudo-randomly chosen hole for a bounded window, judges button presses,
// keeps saturating hit/miss counters and ends the game after GAME_TICKS ticks.
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   start_i     in   start pulse, honoured in IDLE and DONE only
//   btn_i[2:0]  in   synchronised button levels, bit0 = hole 1
//   led_o[2:0]  out  one-hot target hole, 0 when no zombie
//   score_o     out  hits this game (saturating)
//   misses_o    out  timeouts + wrong whacks this game (saturating)
//   busy_o      out  1 while in GAP or UP
//   gameover_o  out  1 while in DONE
// ---------------------------------------------------------------------------
module zombie_round_ctrl
  import zombie_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int UP_TICKS   = 8,
  parameter int GAP_TICKS  = 4,
  parameter int GAME_TICKS = 120,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         btn_i,
  output logic [2:0]         led_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] misses_o,
  output logic               busy_o,
  output logic               gameover_o
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WIN_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int WIN_W   = $clog2(WIN_MAX + 1);
  localparam int GAME_W  = $clog2(GAME_TICKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [WIN_W-1:0]   GAP_LAST   = WIN_W'(GAP_TICKS - 1);
  localparam logic [WIN_W-1:0]   UP_LAST    = WIN_W'(UP_TICKS - 1);
  localparam logic [GAME_W-1:0]  GAME_LAST  = GAME_W'(GAME_TICKS - 1);

  // Increment unless already at the all-ones ceiling.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic en);
    logic [SCORE_W-1:0] r;
    if (en && (v != {SCORE_W{1'b1}})) begin
      r = v + SCORE_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [GAME_W-1:0]  game_q, game_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] miss_q, miss_d;
  logic [2:0]         led_q, led_d;
  logic [2:0]         btn_q;
  logic               busy_q, busy_d;
  logic               gameover_q, gameover_d;

  logic [7:0] lfsr_s;
  logic       lfsr_unused_s;
  logic       active_s;
  logic       tick_s;
  logic [2:0] rise_s;
  logic       hit_s;
  logic       wrong_s;
  logic       timeout_s;

  zombie_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .q_o (lfsr_s)
  );

  // only the low two LFSR bits pick the hole
  assign lfsr_unused_s = ^lfsr_s[7:2];

  assign active_s  = (state_q == ST_GAP) || (state_q == ST_UP);
  assign tick_s    = active_s && (presc_q == PRESC_LAST);
  assign rise_s    = btn_i & ~btn_q;
  // led_q is the target mask while in UP; a hit outranks any wrong press
  assign hit_s     = (state_q == ST_UP) && (|(rise_s & led_q));
  assign wrong_s   = (state_q == ST_UP) && !hit_s && (|(rise_s & ~led_q));
  assign timeout_s = (state_q == ST_UP) && !hit_s && tick_s && (win_q == UP_LAST);

  // next-state, counters and LED decode
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    win_d   = win_q;
    game_d  = game_q;
    score_d = score_q;
    miss_d  = miss_q;
    led_d   = led_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        led_d = 3'b000;
        if (start_i) begin
          state_d = ST_GAP;
          score_d = {SCORE_W{1'b0}};
          miss_d  = {SCORE_W{1'b0}};
          game_d  = {GAME_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_GAP: begin
        if (tick_s && (win_q == GAP_LAST)) begin
          state_d = ST_UP;
          led_d   = hole_onehot(lfsr_s[1:0]);
        end else begin
          led_d = 3'b000;
        end
      end
      ST_UP: begin
        if (hit_s) begin
          score_d = sat_inc(score_q, 1'b1);
          led_d   = 3'b000;
          state_d = ST_GAP;
        end else if (timeout_s) begin
          // a wrong press on the timeout tick is counted as well
          miss_d  = sat_inc(sat_inc(miss_q, wrong_s), 1'b1);
          led_d   = 3'b000;
          state_d = ST_GAP;
        end else begin
          miss_d = sat_inc(miss_q, wrong_s);
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = 3'b000;
      end
    endcase

    // game end overrides the GAP/UP transition but keeps this cycle's judgement
    if (tick_s) begin
      game_d = game_q + GAME_W'(1);
      if (game_q == GAME_LAST) begin
        state_d = ST_DONE;
        led_d   = 3'b000;
      end else begin
        game_d = game_q + GAME_W'(1);
      end
    end else begin
      game_d = game_d;
    end

    // prescaler and window restart on every state change (includes start)
    if (state_d != state_q) begin
      presc_d = {PRESC_W{1'b0}};
      win_d   = {WIN_W{1'b0}};
    end else if (tick_s) begin
      presc_d = {PRESC_W{1'b0}};
      win_d   = win_q + WIN_W'(1);
    end else if (active_s) begin
      presc_d = presc_q + PRESC_W'(1);
    end else begin
      presc_d = {PRESC_W{1'b0}};
      win_d   = {WIN_W{1'b0}};
    end

    busy_d     = (state_d == ST_GAP) || (state_d == ST_UP);
    gameover_d = (state_d == ST_DONE);
  end

  // state, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= {PRESC_W{1'b0}};
      win_q      <= {WIN_W{1'b0}};
      game_q     <= {GAME_W{1'b0}};
      score_q    <= {SCORE_W{1'b0}};
      miss_q     <= {SCORE_W{1'b0}};
      led_q      <= 3'b000;
      btn_q      <= 3'b000;
      busy_q     <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      win_q      <= win_d;
      game_q     <= game_d;
      score_q    <= score_d;
      miss_q     <= miss_d;
      led_q      <= led_d;
      btn_q      <= btn_i;
      busy_q     <= busy_d;
      gameover_q <= gameover_d;
    end
  end

  assign led_o      = led_q;
  assign score_o    = score_q;
  assign misses_o   = miss_q;
  assign busy_o     = busy_q;
  assign gameover_o = gameover_q;

endmodule
